// File: rtl/regfile_writeback.sv
// Write-side front end for the register file: round-robin arbitration of two
// write-back producers, a registered write port, and a same-cycle read bypass.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module regfile_writeback #(
  parameter int unsigned WIDTH      = `WORD_WIDTH,
  parameter int unsigned COUNT      = `REG_COUNT,
  parameter int unsigned ADDR_WIDTH = $clog2(COUNT),
  parameter bit          ZERO_REG   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [WIDTH-1:0]      s0_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [WIDTH-1:0]      s1_data,
  output logic [ADDR_WIDTH-1:0] addr_d,
  output logic                  we_d,
  output logic [WIDTH-1:0]      d,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  fwd_a_hit,
  output logic [WIDTH-1:0]      fwd_a,
  output logic                  fwd_b_hit,
  output logic [WIDTH-1:0]      fwd_b
);

  // last = index of the source granted most recently
  logic                  last;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;
  logic                  sel_drop;

  // Round-robin grant; nothing is granted while reset is held
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    sel_addr = s0_addr;
    sel_data = s0_data;
    if (!rst) begin
      gnt0 = s0_valid && (!s1_valid || last);
      gnt1 = s1_valid && (!s0_valid || !last);
    end
    if (gnt1) begin
      sel_addr = s1_addr;
      sel_data = s1_data;
    end
    gnt_any  = gnt0 || gnt1;
    sel_drop = ZERO_REG && (sel_addr == '0);
  end

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last   <= 1'b1;
      we_d   <= 1'b0;
      addr_d <= '0;
      d      <= '0;
    end else begin
      we_d <= gnt_any && !sel_drop;
      if (gnt_any) begin
        last   <= gnt1;
        addr_d <= sel_addr;
        d      <= sel_data;
      end
    end
  end

  // Bypass of the write currently on the port
  always_comb begin
    fwd_a_hit = we_d && (addr_d == addr_a);
    fwd_b_hit = we_d && (addr_d == addr_b);
    fwd_a     = fwd_a_hit ? d : '0;
    fwd_b     = fwd_b_hit ? d : '0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration/regfile model.
module tb_regfile_writeback;
  localparam int unsigned W  = 16;
  localparam int unsigned C  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_addr, s1_addr, addr_a, addr_b;
  logic [W-1:0]  s0_data, s1_data;

  logic          z0_s0_ready, z0_s1_ready, z0_we_d, z0_fa_hit, z0_fb_hit;
  logic [AW-1:0] z0_addr_d;
  logic [W-1:0]  z0_d, z0_fa, z0_fb;
  logic          z1_s0_ready, z1_s1_ready, z1_we_d, z1_fa_hit, z1_fb_hit;
  logic [AW-1:0] z1_addr_d;
  logic [W-1:0]  z1_d, z1_fa, z1_fb;

  int total = 0;
  int bad   = 0;

  logic         rf_clear;
  logic [W-1:0] rf0 [C];
  logic [W-1:0] rf1 [C];

  always #5 clk = ~clk;

  regfile_writeback #(.WIDTH(W), .COUNT(C), .ADDR_WIDTH(AW), .ZERO_REG(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(z0_s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(z0_s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .addr_d(z0_addr_d), .we_d(z0_we_d), .d(z0_d),
    .addr_a(addr_a), .addr_b(addr_b),
    .fwd_a_hit(z0_fa_hit), .fwd_a(z0_fa), .fwd_b_hit(z0_fb_hit), .fwd_b(z0_fb));

  regfile_writeback #(.WIDTH(W), .COUNT(C), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(z1_s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(z1_s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .addr_d(z1_addr_d), .we_d(z1_we_d), .d(z1_d),
    .addr_a(addr_a), .addr_b(addr_b),
    .fwd_a_hit(z1_fa_hit), .fwd_a(z1_fa), .fwd_b_hit(z1_fb_hit), .fwd_b(z1_fb));

  // Register files attached to each write port
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < C; i++) begin
        rf0[i] <= '0;
        rf1[i] <= '0;
      end
    end else begin
      if (z0_we_d) rf0[z0_addr_d] <= z0_d;
      if (z1_we_d) rf1[z1_addr_d] <= z1_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rf_clear = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_addr = '0; s1_addr = '0; s0_data = '0; s1_data = '0;
    addr_a = '0; addr_b = '0;
    tick();
    tick();
    rst = 1'b0; rf_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_clear = 1'b1;
    s0_valid = 1'b1; s0_addr = 3'd3; s0_data = 16'd5;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    addr_a = '0; addr_b = '0;
    tick();
    total++;
    if ({z0_s0_ready, z0_s1_ready, z0_we_d, z0_fa_hit, z0_fb_hit} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000",
                      {z0_s0_ready, z0_s1_ready, z0_we_d, z0_fa_hit, z0_fb_hit});
    end
    total++;
    if (z0_addr_d !== 3'd0 || z0_d !== 16'd0 || z0_fa !== 16'd0 || z0_fb !== 16'd0) begin
      bad++; $display("FAIL reset_data: got addr=%0d d=%0d fa=%0d fb=%0d want all 0",
                      z0_addr_d, z0_d, z0_fa, z0_fb);
    end
    tick();
    rst = 1'b0; rf_clear = 1'b0;
    #1;
    total++;
    if (z0_s0_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", z0_s0_ready);
    end
  endtask

  // Continues from test_reset: s0 -> r3 <= 5 is accepted at the next edge
  task automatic test_single_write();
    tick();
    s0_valid = 1'b0;
    addr_a = 3'd3;
    #1;
    total++;
    if (z0_we_d !== 1'b1 || z0_addr_d !== 3'd3 || z0_d !== 16'd5) begin
      bad++; $display("FAIL single_port: got we=%b addr=%0d d=%0d want 1 3 5",
                      z0_we_d, z0_addr_d, z0_d);
    end
    total++;
    if (z0_fa_hit !== 1'b1 || z0_fa !== 16'd5) begin
      bad++; $display("FAIL single_fwd: got hit=%b val=%0d want 1 5", z0_fa_hit, z0_fa);
    end
    tick();
    total++;
    if (rf0[3] !== 16'd5 || z0_fa_hit !== 1'b0 || z0_we_d !== 1'b0) begin
      bad++; $display("FAIL single_commit: got rf=%0d hit=%b we=%b want 5 0 0",
                      rf0[3], z0_fa_hit, z0_we_d);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] n0, n1;
    do_reset();
    n0 = 16'd100; n1 = 16'd200;
    s0_valid = 1'b1; s0_addr = 3'd1; s0_data = n0;
    s1_valid = 1'b1; s1_addr = 3'd2; s1_data = n1;
    for (int c = 0; c < 4; c++) begin
      logic exp1;
      exp1 = (c % 2) == 1;
      #1;
      total++;
      if (z0_s0_ready !== !exp1 || z0_s1_ready !== exp1) begin
        bad++; $display("FAIL rr_grant[%0d]: got %b%b want %b%b", c,
                        z0_s0_ready, z0_s1_ready, !exp1, exp1);
      end
      tick();
      total++;
      if (z0_we_d !== 1'b1 || z0_addr_d !== (exp1 ? 3'd2 : 3'd1) ||
          z0_d !== (exp1 ? n1 : n0)) begin
        bad++; $display("FAIL rr_port[%0d]: got we=%b addr=%0d d=%0d want 1 %0d %0d", c,
                        z0_we_d, z0_addr_d, z0_d, exp1 ? 2 : 1, exp1 ? n1 : n0);
      end
      if (exp1) begin n1 = n1 + 16'd1; s1_data = n1; end
      else      begin n0 = n0 + 16'd1; s0_data = n0; end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    s0_valid = 1'b1; s0_addr = 3'd7; s0_data = 16'd10;
    s1_valid = 1'b1; s1_addr = 3'd7; s1_data = 16'd20;
    #1;
    total++;
    if (z0_s0_ready !== 1'b1 || z0_s1_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got %b%b want 10", z0_s0_ready, z0_s1_ready);
    end
    tick();
    s0_valid = 1'b0;
    #1;
    total++;
    if (z0_s1_ready !== 1'b1 || z0_d !== 16'd10) begin
      bad++; $display("FAIL b2b_second: got rdy=%b d=%0d want 1 10", z0_s1_ready, z0_d);
    end
    tick();
    s1_valid = 1'b0;
    tick();
    total++;
    if (rf0[7] !== 16'd20) begin
      bad++; $display("FAIL b2b_final: got %0d want 20", rf0[7]);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    s1_valid = 1'b1; s1_addr = 3'd0; s1_data = 16'd9;
    #1;
    total++;
    if (z1_s1_ready !== 1'b1 || z0_s1_ready !== 1'b1) begin
      bad++; $display("FAIL zero_ready: got z1=%b z0=%b want 1 1", z1_s1_ready, z0_s1_ready);
    end
    tick();
    s1_valid = 1'b0;
    total++;
    if (z1_we_d !== 1'b0 || z0_we_d !== 1'b1) begin
      bad++; $display("FAIL zero_we: got z1=%b z0=%b want 0 1", z1_we_d, z0_we_d);
    end
    tick();
    total++;
    if (rf1[0] !== 16'd0 || rf0[0] !== 16'd9) begin
      bad++; $display("FAIL zero_rf: got z1=%0d z0=%0d want 0 9", rf1[0], rf0[0]);
    end
    // discarded transfer still counts as s1 winning, so s0 takes the next contention
    s0_valid = 1'b1; s0_addr = 3'd5; s0_data = 16'd1;
    s1_valid = 1'b1; s1_addr = 3'd6; s1_data = 16'd2;
    #1;
    total++;
    if (z1_s0_ready !== 1'b1 || z1_s1_ready !== 1'b0) begin
      bad++; $display("FAIL zero_last: got %b%b want 10", z1_s0_ready, z1_s1_ready);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    s0_valid = 1'b1; s0_addr = 3'd4; s0_data = 16'd6; addr_a = 3'd4;
    tick();
    total++;
    if (z0_we_d !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: got we=%b want 1", z0_we_d);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (z0_we_d !== 1'b0 || z0_fa_hit !== 1'b0 || z0_fa !== 16'd0 || z0_s0_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_async: got we=%b hit=%b fa=%0d rdy=%b want 0 0 0 0",
                      z0_we_d, z0_fa_hit, z0_fa, z0_s0_ready);
    end
    tick();
    tick();
    total++;
    if (rf0[4] !== 16'd0 || z0_addr_d !== 3'd0 || z0_d !== 16'd0) begin
      bad++; $display("FAIL midrst_drop: got rf=%0d addr=%0d d=%0d want 0 0 0",
                      rf0[4], z0_addr_d, z0_d);
    end
    rst = 1'b0; s0_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0]  exp_rf [C];
    int            prev_winner;
    logic          pend_v;
    logic [AW-1:0] pend_a, hold_a;
    logic [W-1:0]  pend_d, hold_d;
    do_reset();
    for (int i = 0; i < C; i++) exp_rf[i] = '0;
    prev_winner = 1;
    pend_v = 1'b0; pend_a = '0; pend_d = '0; hold_a = '0; hold_d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int  win;
      bit  e_hit_a, e_hit_b;
      if (!s0_valid && ($urandom % 3 != 0)) begin
        s0_valid = 1'b1; s0_addr = AW'($urandom); s0_data = W'($urandom);
      end
      if (!s1_valid && ($urandom % 3 != 0)) begin
        s1_valid = 1'b1; s1_addr = AW'($urandom); s1_data = W'($urandom);
      end
      addr_a = AW'($urandom); addr_b = AW'($urandom);
      #1;
      if (s0_valid && s1_valid) win = 1 - prev_winner;
      else if (s0_valid)        win = 0;
      else if (s1_valid)        win = 1;
      else                      win = -1;
      total++;
      if (z0_s0_ready !== (win == 0) || z0_s1_ready !== (win == 1) ||
          z1_s0_ready !== (win == 0) || z1_s1_ready !== (win == 1)) begin
        bad++; $display("FAIL rand_grant[%0d]: got %b%b/%b%b want winner %0d", cyc,
                        z0_s0_ready, z0_s1_ready, z1_s0_ready, z1_s1_ready, win);
      end
      e_hit_a = pend_v && (pend_a == addr_a);
      e_hit_b = pend_v && (pend_a == addr_b);
      total++;
      if (z0_fa_hit !== e_hit_a || z0_fa !== (e_hit_a ? pend_d : '0) ||
          z0_fb_hit !== e_hit_b || z0_fb !== (e_hit_b ? pend_d : '0)) begin
        bad++; $display("FAIL rand_fwd[%0d]: got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d",
                        cyc, z0_fa_hit, z0_fa, z0_fb_hit, z0_fb,
                        e_hit_a, e_hit_a ? pend_d : '0, e_hit_b, e_hit_b ? pend_d : '0);
      end
      tick();
      if (pend_v) exp_rf[pend_a] = pend_d;
      pend_v = (win >= 0);
      if (win == 0) begin pend_a = s0_addr; pend_d = s0_data; s0_valid = 1'b0; end
      if (win == 1) begin pend_a = s1_addr; pend_d = s1_data; s1_valid = 1'b0; end
      if (win >= 0) begin prev_winner = win; hold_a = pend_a; hold_d = pend_d; end
      total++;
      if (z0_we_d !== pend_v || z0_addr_d !== hold_a || z0_d !== hold_d ||
          z1_we_d !== (pend_v && pend_a != 0)) begin
        bad++; $display("FAIL rand_port[%0d]: got we=%b addr=%0d d=%0d zwe=%b want %b %0d %0d %b",
                        cyc, z0_we_d, z0_addr_d, z0_d, z1_we_d, pend_v, hold_a, hold_d,
                        pend_v && pend_a != 0);
      end
      for (int i = 0; i < C; i++) begin
        total++;
        if (rf0[i] !== exp_rf[i]) begin
          bad++; $display("FAIL rand_rf[%0d] r%0d: got %0d want %0d", cyc, i, rf0[i], exp_rf[i]);
        end
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; rf_clear = 1'b1;
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_zero_reg();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for `regfile`. It accepts register write-back results from two producers (ALU result path and load-unit path) over valid/ready handshakes and arbitrates between them round-robin. The winning result is registered and driven onto the regfile write port (`addr_d`, `we_d`, `d`). It also provides a combinational bypass, so readers on ports A/B see a value in the same cycle it is presented on the write port.

## Interface
- `WIDTH`, default `` `WORD_WIDTH ``: data width of results and write port.
- `COUNT`, default `` `REG_COUNT ``: number of architectural registers.
- `ADDR_WIDTH`, default `$clog2(COUNT)`: register address width.
- `ZERO_REG`, default 0: when 1, writes to address 0 are accepted and discarded.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high (one clock domain).
- `s0_valid`  in  1  source 0 (ALU) has a result.
- `s0_ready`  out  1  source 0 result accepted this cycle.
- `s0_addr`  in  ADDR_WIDTH  destination register, source 0.
- `s0_data`  in  WIDTH  result value, source 0.
- `s1_valid`  in  1  source 1 (load unit) has a result.
- `s1_ready`  out  1  source 1 result accepted this cycle.
- `s1_addr`  in  ADDR_WIDTH  destination register, source 1.
- `s1_data`  in  WIDTH  result value, source 1.
- `addr_d`  out  ADDR_WIDTH  regfile write address.
- `we_d`  out  1  regfile write enable.
- `d`  out  WIDTH  regfile write data.
- `addr_a`  in  ADDR_WIDTH  regfile port A read address (tapped).
- `addr_b`  in  ADDR_WIDTH  regfile port B read address (tapped).
- `fwd_a_hit`  out  1  port A address matches the in-flight write.
- `fwd_a`  out  WIDTH  bypass value for port A.
- `fwd_b_hit`  out  1  port B address matches the in-flight write.
- `fwd_b`  out  WIDTH  bypass value for port B.

## Operation
- **Handshake**
  - A transfer occurs on a source when `sX_valid && sX_ready` at a rising edge.
  - `sX_ready` is combinational: the grant for that source. It is never asserted without `sX_valid`.
  - A source must hold addr/data stable while valid and unaccepted.
- **Arbiter**
  - One grant per cycle.
  - Only one source valid: that source is granted.
  - Both sources valid: grant goes to the source that did not win last time.
  - State `last` is 1 bit and is updated only when a grant occurs.
  - Reset value of `last` is 1, so source 0 wins the first contention.
- **Output stage**
  - Registered. On a granted transfer: `addr_d<=addr`, `d<=data`, `we_d<=1`.
  - With no transfer: `we_d<=0`; `addr_d` and `d` hold their previous values.
  - The regfile commits the write at the edge ending the cycle in which `we_d=1`.
- **ZERO_REG=1**
  - A transfer with addr 0 is handshaken normally, but `we_d` stays 0 for it.
  - The transfer still updates `last`.
- **Bypass**
  - `fwd_a_hit = we_d && (addr_d==addr_a)`.
  - `fwd_a = fwd_a_hit ? d : 0`.
  - Port B is identical. Both are purely combinational.
- **Throughput**: one write per cycle; no internal buffering beyond the output register. The regfile never stalls.

## Timing
- Reset (async assert) forces `we_d=0`, `addr_d=0`, `d=0`, `last=1`.
- While `rst=1`: `s0_ready=s1_ready=0`, `fwd_*_hit=0`, `fwd_*=0`.
- Reset asserted mid-operation: any in-flight write is dropped immediately (`we_d` falls without waiting for a clock edge). A transfer in the same cycle is not accepted.
- Deassertion takes effect at the first rising edge after `rst` falls.
- Latency: transfer at edge N → `we_d=1` during cycle N..N+1 → regfile holds the value after edge N+1.
- Bypass is valid during cycle N..N+1. Direct regfile reads are valid from N+1 onwards.
- Back-to-back writes to the same address: issued in arbitration order; the later grant wins in the regfile.
- Both sources valid to the same address in one cycle: serialized over two cycles per the round-robin order. The final value is from the second grant.

## Test plan
- Reset with `s0_valid=1`: all outputs 0 during reset. After release, `s0_ready=1` in the first cycle.
- `s0` writes 5 to r3, single cycle: next cycle `we_d=1`, `addr_d=3`, `d=5`. With `addr_a=3`: `fwd_a_hit=1`, `fwd_a=5`. One cycle later regfile port A reads 5 and `fwd_a_hit=0`.
- Both sources valid for 4 cycles, s0→r1 and s1→r2, with incrementing data: grants alternate s0,s1,s0,s1. `we_d` is high for 4 consecutive cycles.
- Both sources valid to r7 (s0 data 10, s1 data 20), from reset: s0 granted first, s1 second. Regfile r7 ends at 20.
- `ZERO_REG=1`, s1 writes 9 to r0: `s1_ready=1`, but `we_d` stays 0 and r0 reads 0. `ZERO_REG=0`: r0 reads 9.
- Reset pulsed while `we_d=1` for r4←6: `we_d` drops asynchronously and r4 stays 0.
